// File: rtl/bus_pkg.sv
// Shared definitions for the arbiter and the bus fabric it feeds.
package bus_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Width of a master index; never narrower than one bit so that a
  // single-master build still has a legal vector.
  function automatic int midx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Default two-core build of the SoC.
  localparam int N_MASTER_DEF = 2;
  localparam int MIDX_W       = midx_w(N_MASTER_DEF);

endpackage

// File: rtl/bus_arb_if.sv
// Handshake and address/data signals between the cores, the arbiter and busctl.
interface bus_arb_if #(
  parameter int AD_LEN    = 32,
  parameter int BUS_WIDTH = 32,
  parameter int N_MASTER  = 2
);

  logic [N_MASTER-1:0]        req_i;
  logic [N_MASTER*AD_LEN-1:0] ad_i;
  logic [N_MASTER-1:0]        gnt_o;
  logic [N_MASTER-1:0]        ack_o;
  logic [BUS_WIDTH-1:0]       rdata_o;
  logic [AD_LEN-1:0]          ad_o;
  logic [BUS_WIDTH-1:0]       data_i;

  // Arbiter side.
  modport slave (
    input  req_i, ad_i, data_i,
    output gnt_o, ack_o, rdata_o, ad_o
  );

  // Requesting cores plus the busctl return path.
  modport master (
    output req_i, ad_i, data_i,
    input  gnt_o, ack_o, rdata_o, ad_o
  );

endinterface

// File: rtl/bus_arb_rr_pick.sv
// Round-robin pick: rotate the eligible mask so ptr sits at bit 0, take the
// lowest set bit, then rotate the offset back into an absolute index.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N_MASTER = 2
) (
  input  logic [N_MASTER-1:0]         elig,
  input  logic [midx_w(N_MASTER)-1:0] ptr,
  output logic                        valid,
  output logic [midx_w(N_MASTER)-1:0] win
);

  localparam int IDX_W = midx_w(N_MASTER);

  logic [2*N_MASTER-1:0] dbl;
  logic [N_MASTER-1:0]   rot;
  logic [IDX_W-1:0]      off;
  logic [IDX_W:0]        sum;

  // Rotate, priority-encode from bit 0 and map the offset back modulo N_MASTER.
  always_comb begin
    dbl   = {elig, elig} >> ptr;
    rot   = dbl[N_MASTER-1:0];
    off   = '0;
    valid = 1'b0;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = IDX_W'(i);
        valid = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(N_MASTER)) begin
      sum = sum - (IDX_W + 1)'(N_MASTER);
    end
    win = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/bus_arb.sv
// Round-robin arbiter in front of busctl: grants one core at a time, forwards
// its address, waits the fabric read latency and returns the captured data.
module bus_arb
  import bus_pkg::*;
#(
  parameter int AD_LEN    = 32,
  parameter int BUS_WIDTH = 32,
  parameter int N_MASTER  = 2,
  parameter int RD_LAT    = 1
) (
  input logic       clk_i,
  input logic       reset_i,
  bus_arb_if.slave  bus
);

  localparam int IDX_W = midx_w(N_MASTER);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     ptr_nxt;
  logic [IDX_W-1:0]     win;
  logic                 pick_vld;
  logic [CNT_W-1:0]     cnt;
  logic [N_MASTER-1:0]  elig;
  logic [N_MASTER-1:0]  gnt_q;
  logic [N_MASTER-1:0]  ack_q;
  logic [AD_LEN-1:0]    ad_q;
  logic [BUS_WIDTH-1:0] rdata_q;
  logic [AD_LEN-1:0]    ad_arr [N_MASTER];
  logic                 do_grant;
  logic                 do_done;

  // Unpack the flat per-master address bus into an indexable array.
  always_comb begin
    for (int k = 0; k < N_MASTER; k++) begin
      ad_arr[k] = bus.ad_i[k*AD_LEN +: AD_LEN];
    end
  end

  // A master that is being acked this cycle sits out one round.
  assign elig    = bus.req_i & ~ack_q;
  assign ptr_nxt = (win == IDX_W'(N_MASTER - 1)) ? '0 : win + 1'b1;

  rr_pick #(
    .N_MASTER (N_MASTER)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .valid (pick_vld),
    .win   (win)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= ARB_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: leave IDLE on a winner, leave BUSY when the last latency edge arrives.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (pick_vld) state_nxt = ARB_BUSY;
      ARB_BUSY: if (cnt == CNT_W'(1)) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // FSM outputs: strobes that steer the datapath registers.
  always_comb begin
    do_grant = 1'b0;
    do_done  = 1'b0;
    case (state)
      ARB_IDLE: do_grant = pick_vld;
      ARB_BUSY: do_done  = (cnt == CNT_W'(1));
      default:  ;
    endcase
  end

  // Grant/ack/counter/pointer and the address/data capture registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr     <= '0;
      cnt     <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      ad_q    <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      if (do_grant) begin
        gnt_q <= N_MASTER'(1) << win;
        ad_q  <= ad_arr[win];
        cnt   <= CNT_W'(RD_LAT);
        ptr   <= ptr_nxt;
      end else if (do_done) begin
        rdata_q <= bus.data_i;
        ack_q   <= gnt_q;
        gnt_q   <= '0;
      end else if (state == ARB_BUSY) begin
        cnt <= cnt - 1'b1;
      end else begin
        gnt_q <= '0;
      end
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.ack_o   = ack_q;
  assign bus.ad_o    = ad_q;
  assign bus.rdata_o = rdata_q;

endmodule
